// File: rtl/mem_bus_arbiter.sv
// Two-master memory bus arbiter: one transaction at a time, fixed memory
// latency, round-robin priority between the CPU core (m0) and the
// loader/DMA engine (m1), with an optional bus lock that lets the owner
// run read-modify-write sequences without interruption.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_rd,
  input  logic              m0_wr,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_rd,
  input  logic              m1_wr,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // The counter is loaded with MEM_LAT-1 so the strobe lasts MEM_LAT cycles.
  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic fav_q, fav_d;
  logic lock_valid_q, lock_valid_d;
  logic lock_owner_q, lock_owner_d;
  logic winner_q, winner_d;
  logic wr_op_q, wr_op_d;

  logic m0_gnt_d, m1_gnt_d, m0_ack_d, m1_ack_d;
  logic mem_rd_d, mem_wr_d, busy_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d, rdata_d;

  logic valid0, valid1, lock_hold, elig0, elig1, win, win_wr;

  // A request counts only when it carries a command. A lock is honoured only
  // while the owner keeps its lock line high, so dropping it frees the bus in
  // the same cycle. With both eligible, the favoured master (fav_q) wins.
  assign valid0    = m0_req & (m0_rd | m0_wr);
  assign valid1    = m1_req & (m1_rd | m1_wr);
  assign lock_hold = lock_valid_q & (lock_owner_q ? m1_lock : m0_lock);
  assign elig0     = valid0 & ~(lock_hold & lock_owner_q);
  assign elig1     = valid1 & ~(lock_hold & ~lock_owner_q);
  assign win       = (elig0 & elig1) ? fav_q : elig1;
  assign win_wr    = win ? m1_wr : m0_wr;

  // Next-state and next-output logic; every register holds unless a state acts on it.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fav_d        = fav_q;
    lock_valid_d = lock_valid_q;
    lock_owner_d = lock_owner_q;
    winner_d     = winner_q;
    wr_op_d      = wr_op_q;
    m0_gnt_d     = m0_gnt;
    m1_gnt_d     = m1_gnt;
    m0_ack_d     = m0_ack;
    m1_ack_d     = m1_ack;
    mem_rd_d     = mem_rd;
    mem_wr_d     = mem_wr;
    busy_d       = busy;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    rdata_d      = rdata;

    case (state_q)
      IDLE: begin
        lock_valid_d = lock_hold;
        if (elig0 | elig1) begin
          winner_d    = win;
          wr_op_d     = win_wr;
          m0_gnt_d    = ~win;
          m1_gnt_d    = win;
          busy_d      = 1'b1;
          mem_addr_d  = win ? m1_addr : m0_addr;
          mem_wdata_d = win ? m1_wdata : m0_wdata;
          mem_wr_d    = win_wr;
          mem_rd_d    = ~win_wr;
          cnt_d       = LAT_INIT;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!wr_op_q) begin
            rdata_d = mem_rdata;
          end
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          m0_ack_d = ~winner_q;
          m1_ack_d = winner_q;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        fav_d        = ~winner_q;
        lock_valid_d = winner_q ? m1_lock : m0_lock;
        lock_owner_d = winner_q;
        m0_gnt_d     = 1'b0;
        m1_gnt_d     = 1'b0;
        m0_ack_d     = 1'b0;
        m1_ack_d     = 1'b0;
        busy_d       = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; a low reset at the edge aborts everything at once.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      fav_q        <= 1'b0;
      lock_valid_q <= 1'b0;
      lock_owner_q <= 1'b0;
      winner_q     <= 1'b0;
      wr_op_q      <= 1'b0;
      m0_gnt       <= 1'b0;
      m1_gnt       <= 1'b0;
      m0_ack       <= 1'b0;
      m1_ack       <= 1'b0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      busy         <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      rdata        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fav_q        <= fav_d;
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
      winner_q     <= winner_d;
      wr_op_q      <= wr_op_d;
      m0_gnt       <= m0_gnt_d;
      m1_gnt       <= m1_gnt_d;
      m0_ack       <= m0_ack_d;
      m1_ack       <= m1_ack_d;
      mem_rd       <= mem_rd_d;
      mem_wr       <= mem_wr_d;
      busy         <= busy_d;
      mem_addr     <= mem_addr_d;
      mem_wdata    <= mem_wdata_d;
      rdata        <= rdata_d;
    end
  end

endmodule
